// File: rtl/music_box_pkg.sv
// Shared constants and types for the music box record/playback path.
package music_box_pkg;

    localparam int RUN_W = 10;

    localparam logic [4:0] IDLE_STATE = 5'd0;
    localparam logic [4:0] REC_STATE  = 5'd4;
    localparam logic [4:0] PLAY_STATE = 5'd5;

    localparam logic [5:0]       KEYS_RELEASED = 6'h3F;
    localparam logic [RUN_W-1:0] RUN_MAX       = '1;

    typedef struct packed {
        logic [5:0]       keys;
        logic [RUN_W-1:0] run;
    } key_entry_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_FETCH,
        P_RUN,
        P_DONE
    } play_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Single-key debouncer: output follows the raw input only after it
// has differed from the current output for DEBOUNCE_MS cycles in a row.
module key_debouncer #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic CLK_1Khz,
    input  logic reset_n,
    input  logic raw,
    output logic debounced
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK_1Khz) begin
        if (!reset_n) begin
            cnt       <= '0;
            debounced <= 1'b1;
        end else if (raw == debounced) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
            debounced <= raw;
            cnt       <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/music_key_sequencer.sv
// Debounces six keys, records run-length encoded key activity into RAM
// and replays it cycle-exact onto the active-low tone-stage bus.
module music_key_sequencer
    import music_box_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic                     CLK_1Khz,
    input  logic                     reset_n,
    input  logic [4:0]               currentState,
    input  logic [5:0]               input_RawKey,
    output logic [5:0]               output_MusicKey,
    output logic [$clog2(DEPTH):0]   recordingLength,
    output logic                     recordFull,
    output logic                     playbackActive,
    output logic                     playbackDone
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [5:0]       deb;
    logic [4:0]       state_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_addr;
    logic [5:0]       cur_vec;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_cnt;
    play_state_t      p_state;
    key_entry_t       mem [DEPTH];
    key_entry_t       rd_q;
    logic             rec_enter;
    logic             rec_now;
    logic             rec_exit;
    logic             seg_end;
    logic             we;

    for (genvar i = 0; i < 6; i++) begin : g_deb
        key_debouncer #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_deb (
            .CLK_1Khz (CLK_1Khz),
            .reset_n  (reset_n),
            .raw      (input_RawKey[i]),
            .debounced(deb[i])
        );
    end

    assign rec_enter = currentState == REC_STATE && state_q != REC_STATE;
    assign rec_now   = currentState == REC_STATE && state_q == REC_STATE;
    assign rec_exit  = currentState != REC_STATE && state_q == REC_STATE;
    assign seg_end   = rec_now && (deb != cur_vec || run == RUN_MAX);
    assign we        = (seg_end || rec_exit) && wr_ptr != PTR_FULL;

    assign recordingLength = wr_ptr;

    always_ff @(posedge CLK_1Khz) begin
        if (!reset_n) begin
            state_q    <= IDLE_STATE;
            wr_ptr     <= '0;
            recordFull <= 1'b0;
            cur_vec    <= KEYS_RELEASED;
            run        <= '0;
        end else begin
            state_q <= currentState;
            if (we) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (wr_ptr == PTR_LAST) recordFull <= 1'b1;
            end
            if (rec_enter) begin
                wr_ptr     <= '0;
                recordFull <= 1'b0;
                cur_vec    <= deb;
                run        <= RUN_W'(1);
            end else if (seg_end) begin
                cur_vec <= deb;
                run     <= RUN_W'(1);
            end else if (rec_now) begin
                run <= run + RUN_W'(1);
            end
        end
    end

    // Read port always holds mem[rd_ptr], so the next entry is ready
    // at the last cycle of the current run even when runs are 1 long.
    always_comb begin
        rd_addr = rd_ptr[AW-1:0];
        if (currentState != PLAY_STATE) begin
            rd_addr = '0;
        end else if (p_state == P_FETCH ||
                     (p_state == P_RUN && run_cnt == RUN_W'(1))) begin
            rd_addr = AW'(rd_ptr + PW'(1));
        end
    end

    always_ff @(posedge CLK_1Khz) begin
        if (we) mem[wr_ptr[AW-1:0]] <= {cur_vec, run};
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge CLK_1Khz) begin
        if (!reset_n) begin
            p_state         <= P_IDLE;
            rd_ptr          <= '0;
            run_cnt         <= '0;
            output_MusicKey <= KEYS_RELEASED;
            playbackActive  <= 1'b0;
            playbackDone    <= 1'b0;
        end else begin
            playbackDone <= 1'b0;
            if (currentState != PLAY_STATE) begin
                p_state        <= P_IDLE;
                rd_ptr         <= '0;
                playbackActive <= 1'b0;
                output_MusicKey <=
                    (currentState == IDLE_STATE || currentState == REC_STATE)
                    ? deb : KEYS_RELEASED;
            end else begin
                unique case (p_state)
                    P_IDLE: begin
                        output_MusicKey <= KEYS_RELEASED;
                        // one cycle late so a record flush lands first
                        if (state_q == PLAY_STATE) begin
                            if (wr_ptr == '0) begin
                                p_state      <= P_DONE;
                                playbackDone <= 1'b1;
                            end else begin
                                p_state        <= P_FETCH;
                                playbackActive <= 1'b1;
                            end
                        end
                    end
                    P_FETCH: begin
                        output_MusicKey <= rd_q.keys;
                        run_cnt         <= rd_q.run;
                        rd_ptr          <= rd_ptr + PW'(1);
                        p_state         <= P_RUN;
                    end
                    P_RUN: begin
                        if (run_cnt != RUN_W'(1)) begin
                            run_cnt <= run_cnt - RUN_W'(1);
                        end else if (rd_ptr == wr_ptr) begin
                            p_state         <= P_DONE;
                            output_MusicKey <= KEYS_RELEASED;
                            playbackActive  <= 1'b0;
                            playbackDone    <= 1'b1;
                        end else begin
                            output_MusicKey <= rd_q.keys;
                            run_cnt         <= rd_q.run;
                            rd_ptr          <= rd_ptr + PW'(1);
                        end
                    end
                    P_DONE: begin
                        output_MusicKey <= KEYS_RELEASED;
                    end
                    default: begin
                        p_state <= P_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
